// File: rtl/ff_bank_pkg.sv
// Shared definitions for the flip-flop bank arbiter: op encodings, FSM states and the op register layout.
// The LOCKED state exists only when FF_BANK_LOCK_EN is defined.
package ff_bank_pkg;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_TOGGLE = 2'b01;
    localparam logic [1:0] OP_JK     = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    // Op register fields are sized for the largest supported bank and requester count.
    localparam int BANK_W_MAX = 64;
    localparam int ID_W_MAX   = 3;

`ifdef FF_BANK_LOCK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_LOCKED} state_t;
`else
    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
`endif

    typedef struct packed {
        logic [1:0]            op;
        logic [BANK_W_MAX-1:0] a;
        logic [BANK_W_MAX-1:0] b;
        logic [ID_W_MAX-1:0]   id;
    } op_reg_t;

    function automatic logic [BANK_W_MAX-1:0] apply_op(
        input logic [1:0]            op,
        input logic [BANK_W_MAX-1:0] cur,
        input logic [BANK_W_MAX-1:0] a,
        input logic [BANK_W_MAX-1:0] b
    );
        logic [BANK_W_MAX-1:0] res;
        case (op)
            OP_LOAD:   res = a;
            OP_TOGGLE: res = cur ^ a;
            OP_JK:     res = (a & ~cur) | (~b & cur);
            default:   res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ff_bank_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    int idx;

    // Scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[PTR_W'(idx)]) grant = N_REQ'(1) << PTR_W'(idx);
        end
    end

endmodule

// File: rtl/ff_bank_arbiter.sv
// Shares one flip-flop register bank between N_REQ requesters; each granted op updates q one edge later.
// Optional grant locking is enabled with the FF_BANK_LOCK_EN macro.
module ff_bank_arbiter
    import ff_bank_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]       req_lock,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       q,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic                   busy
);

    // state     | meaning
    // ST_IDLE   | no op pending, round-robin arbitration
    // ST_ACTIVE | op pending in op_reg, applied at the next edge
    // ST_LOCKED | grant held by owner (FF_BANK_LOCK_EN only)

    state_t            state, state_nxt;
    op_reg_t           op_reg;
    logic [ID_W-1:0]   rr_ptr;
    logic [N_REQ-1:0]  arb_grant, grant;
    logic              xfer, pend, sel_lock;
    logic [ID_W-1:0]   xfer_id;
    logic [1:0]        sel_op;
    logic [WIDTH-1:0]  sel_a, sel_b;
    logic              unused_bits;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant)
    );

`ifdef FF_BANK_LOCK_EN
    logic [ID_W-1:0] owner;

    always_comb begin
        grant = arb_grant;
        if (state == ST_LOCKED) grant = req_valid & (N_REQ'(1) << owner);
    end
`else
    assign grant = arb_grant;
`endif

    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        xfer_id  = '0;
        sel_op   = OP_NOP;
        sel_a    = '0;
        sel_b    = '0;
        sel_lock = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                xfer_id  = ID_W'(i);
                sel_op   = req_op[2*i +: 2];
                sel_a    = req_a[WIDTH*i +: WIDTH];
                sel_b    = req_b[WIDTH*i +: WIDTH];
                sel_lock = req_lock[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ACTIVE: begin
                state_nxt = xfer ? ST_ACTIVE : ST_IDLE;
`ifdef FF_BANK_LOCK_EN
                if (xfer && sel_lock) state_nxt = ST_LOCKED;
`endif
            end
`ifdef FF_BANK_LOCK_EN
            ST_LOCKED: begin
                if (!req_valid[owner])      state_nxt = ST_IDLE;
                else if (xfer && !sel_lock) state_nxt = ST_ACTIVE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

`ifdef FF_BANK_LOCK_EN
    // LOCKED can hold with or without an op pending, so pending is tracked separately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend  <= 1'b0;
            owner <= '0;
        end else begin
            pend <= xfer;
            if (xfer) owner <= xfer_id;
        end
    end
    assign unused_bits = ^op_reg.id;
`else
    assign pend        = (state == ST_ACTIVE);
    assign unused_bits = ^{op_reg.id, sel_lock};
`endif

    assign busy = pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_reg  <= '0;
            rr_ptr  <= '0;
            q       <= '0;
            done    <= 1'b0;
            done_id <= '0;
        end else begin
            done <= pend;
            if (pend) begin
                q       <= WIDTH'(apply_op(op_reg.op, BANK_W_MAX'(q), op_reg.a, op_reg.b));
                done_id <= ID_W'(op_reg.id);
            end
            if (xfer) begin
                op_reg.op <= sel_op;
                op_reg.a  <= BANK_W_MAX'(sel_a);
                op_reg.b  <= BANK_W_MAX'(sel_b);
                op_reg.id <= ID_W_MAX'(xfer_id);
                rr_ptr    <= (xfer_id == ID_W'(N_REQ - 1)) ? '0 : xfer_id + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Self-checking bench for ff_bank_arbiter: directed vector table, hand sequences and randomized traffic vs a reference model.
`timescale 1ns/1ps
module tb_ff_bank_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid, req_lock, req_ready;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_a, req_b;
    logic [W-1:0]   q;
    logic           done;
    logic [1:0]     done_id;
    logic           busy;

    always #5 clk = ~clk;

    ff_bank_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .q         (q),
        .done      (done),
        .done_id   (done_id),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int         m_ptr, m_pid, m_did, m_owner;
    logic [W-1:0] m_q, m_pa, m_pb;
    logic [1:0] m_pop;
    bit         m_pend, m_done, m_lock;

    typedef struct {
        logic [3:0]  valid;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ready;
        logic [7:0]  q;
        logic        done;
        logic [1:0]  id;
    } vec_t;
    vec_t tab[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // JK per bit: 00 hold, 10 set, 01 clear, 11 toggle
    function automatic logic [W-1:0] ff_rule(input logic [1:0] op, input logic [W-1:0] cur,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = cur;
        if (op == 2'd0) r = a;
        else if (op == 2'd1) r = cur ^ a;
        else if (op == 2'd2) begin
            for (int i = 0; i < W; i++) begin
                if (a[i] && b[i])   r[i] = ~cur[i];
                else if (a[i])      r[i] = 1'b1;
                else if (b[i])      r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic int exp_grant();
        if (m_lock) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_ptr = 0; m_pid = 0; m_did = 0; m_owner = 0;
        m_q = '0; m_pa = '0; m_pb = '0; m_pop = 2'd3;
        m_pend = 0; m_done = 0; m_lock = 0;
    endtask

    // Inputs are driven just after a rising edge; grant is checked at the falling edge.
    task automatic run_cycle(input bit use_tab, input logic [3:0] t_ready, input logic [7:0] t_q,
                             input logic t_done, input logic [1:0] t_id);
        int g;
        logic [3:0] gv;
        @(negedge clk);
        g  = exp_grant();
        gv = (g < 0) ? 4'b0000 : 4'(1 << g);
        chk("req_ready", req_ready, gv);
        if (use_tab) chk("tab_ready", req_ready, t_ready);
        m_done = m_pend;
        if (m_pend) begin
            m_q   = ff_rule(m_pop, m_q, m_pa, m_pb);
            m_did = m_pid;
        end
`ifdef FF_BANK_LOCK_EN
        if (m_lock) begin
            if (!req_valid[m_owner] || (g >= 0 && !req_lock[m_owner])) m_lock = 0;
        end else if (g >= 0 && req_lock[g]) begin
            m_lock  = 1;
            m_owner = g;
        end
`endif
        if (g >= 0) begin
            m_pend = 1;
            m_pop  = req_op[2*g +: 2];
            m_pa   = req_a[W*g +: W];
            m_pb   = req_b[W*g +: W];
            m_pid  = g;
            m_ptr  = (g + 1) % N;
        end else begin
            m_pend = 0;
        end
        @(posedge clk);
        #1;
        chk("q", q, m_q);
        chk("done", done, m_done);
        chk("busy", busy, m_pend);
        chk("done_id", done_id, m_did);
        if (use_tab) begin
            chk("tab_q", q, t_q);
            chk("tab_done", done, t_done);
            if (t_done) chk("tab_done_id", done_id, t_id);
        end
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_op = '1; req_a = '0; req_b = '0; req_lock = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_ready", req_ready, 0);
        reset_n = 1'b1;
        model_clear();
    endtask

    initial begin
        // single op, chained ops, wrap-around with idle gaps
        tab[0] = '{4'b0010, 8'b11_11_00_11, 32'h0000_A500, 32'h0, 4'b0010, 8'h00, 1'b0, 2'd0};
        tab[1] = '{4'b0100, 8'b11_01_11_11, 32'h000F_0000, 32'h0, 4'b0100, 8'hA5, 1'b1, 2'd1};
        tab[2] = '{4'b1000, 8'b10_11_11_11, 32'hF000_0000, 32'h0F00_0000, 4'b1000, 8'hAA, 1'b1, 2'd2};
        tab[3] = '{4'b0000, 8'hFF, 32'h0, 32'h0, 4'b0000, 8'hF0, 1'b1, 2'd3};
        tab[4] = '{4'b0000, 8'hFF, 32'h0, 32'h0, 4'b0000, 8'hF0, 1'b0, 2'd0};
        tab[5] = '{4'b0100, 8'b11_11_11_11, 32'h0, 32'h0, 4'b0100, 8'hF0, 1'b0, 2'd0};
        tab[6] = '{4'b1001, 8'b00_11_11_01, 32'h3C00_00FF, 32'h0, 4'b1000, 8'hF0, 1'b1, 2'd2};
        tab[7] = '{4'b0001, 8'b00_11_11_01, 32'h3C00_00FF, 32'h0, 4'b0001, 8'h3C, 1'b1, 2'd3};
        tab[8] = '{4'b0000, 8'hFF, 32'h0, 32'h0, 4'b0000, 8'hC3, 1'b1, 2'd0};
        tab[9] = '{4'b0000, 8'hFF, 32'h0, 32'h0, 4'b0000, 8'hC3, 1'b0, 2'd0};

        model_clear();
        do_reset();
        for (int v = 0; v < 10; v++) begin
            req_valid = tab[v].valid;
            req_op    = tab[v].op;
            req_a     = tab[v].a;
            req_b     = tab[v].b;
            req_lock  = '0;
            run_cycle(1'b1, tab[v].ready, tab[v].q, tab[v].done, tab[v].id);
        end

        // fairness: all requesters continuously valid from reset
        do_reset();
        req_valid = 4'b1111;
        req_op    = 8'h00;
        req_a     = 32'h4433_2211;
        for (int k = 0; k < 8; k++) begin
            run_cycle(1'b1, 4'(1 << (k % 4)),
                      (k == 0) ? 8'h00 : 8'(8'h11 * ((k - 1) % 4 + 1)),
                      k != 0, 2'((k + 3) % 4));
        end

        // reset one cycle after a transfer discards the pending op
        req_valid = 4'b0001;
        req_op    = 8'b11_11_11_00;
        req_a     = 32'h0000_005A;
        run_cycle(1'b0, 4'b0, 8'h0, 1'b0, 2'd0);
        reset_n = 1'b0;
        idle_inputs();
        #1;
        chk("midrst_q", q, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(posedge clk);
        #1;
        chk("midrst_done_after", done, 0);
        chk("midrst_q_after", q, 0);
        reset_n = 1'b1;
        model_clear();

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            req_valid = 4'($urandom);
            req_op    = 8'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            req_lock  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            run_cycle(1'b0, 4'b0, 8'h0, 1'b0, 2'd0);
        end
        idle_inputs();
        run_cycle(1'b0, 4'b0, 8'h0, 1'b0, 2'd0);

`ifdef FF_BANK_LOCK_EN
        // requester 0 holds the grant for three locked ops while requester 1 waits
        do_reset();
        req_valid = 4'b0011;
        req_op    = 8'h00;
        for (int k = 0; k < 4; k++) begin
            req_lock = (k < 3) ? 4'b0001 : 4'b0000;
            req_a    = {16'h0, 8'h22, 8'(k + 1)};
            run_cycle(1'b1, 4'b0001, (k == 0) ? 8'h00 : 8'(k), k != 0, 2'd0);
        end
        req_lock = 4'b0000;
        run_cycle(1'b1, 4'b0010, 8'h04, 1'b1, 2'd0);
        idle_inputs();
        run_cycle(1'b1, 4'b0000, 8'h22, 1'b1, 2'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
